gyro_spi_serf: RTL and testbench

SPI responder modelling the 6-axis inertial sensor as seen by the robot's SPI initiator. It decodes 16-bit command frames, holds the configuration registers the initiator writes at startup, and serves Z-gyro yaw-rate bytes on read. It also drives the data-ready INT line. It sits opposite the inertial interface, either in the full-chip bench or in the emulation build in place of the physical sensor.

---
 rtl/inert_pkg.sv | 20 ++
 rtl/spi_serf.sv | 86 ++++++++
 rtl/gyro_spi_serf.sv | 119 +++++++++++
 tb/tb_gyro_spi_serf.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/inert_pkg.sv
// Shared constants for the inertial sensor model: register addresses,
// identity byte and command frame layout.
package inert_pkg;

    localparam int         FRAME_BITS_DEF = 16;
    localparam logic [7:0] WHO_AM_I_DEF   = 8'h6A;

    // Frame layout: [15] read/write, [14:8] address, [7:0] write data.
    localparam int RW_BIT    = 15;
    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;

    localparam logic [ADDR_BITS-1:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [ADDR_BITS-1:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [ADDR_BITS-1:0] ADDR_CTRL2_G   = 7'h11;
    localparam logic [ADDR_BITS-1:0] ADDR_CTRL5_C   = 7'h14;
    localparam logic [ADDR_BITS-1:0] ADDR_OUTZ_L_G  = 7'h26;
    localparam logic [ADDR_BITS-1:0] ADDR_OUTZ_H_G  = 7'h27;

endpackage

// File: rtl/spi_serf.sv
// SPI mode-3 serf front end: pin synchronizers, edge detection, bit
// counting, receive shift register and read-data shift register.
module spi_serf
    import inert_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss_n,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  addr_vld,
    output logic [ADDR_BITS-1:0]  rx_addr,
    input  logic [DATA_BITS-1:0]  rd_byte,
    output logic                  frame_done,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_full
);

    logic [2:0]            ss_sync;
    logic [2:0]            sclk_sync;
    logic [1:0]            mosi_sync;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [DATA_BITS-1:0]  tx_shift;

    logic ss_low, ss_fall, ss_rise, sclk_rise, sclk_fall, tx_window;

    // Select and clock reset to their idle-high level so reset release
    // never looks like a pin edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what keeps this chain a chain.
            ss_sync   <= {ss_sync[1:0], ss_n};
            sclk_sync <= {sclk_sync[1:0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign ss_low    = ~ss_sync[1];
    assign ss_fall   =  ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] &  ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1] & ss_low;
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1] & ss_low;
    assign tx_window = (bit_cnt >= 5'd9) && (bit_cnt <= 5'd15);

    // Read lookup fires on the edge that makes bit_cnt 8, using the
    // incoming MOSI bit as address bit 0 so MISO is ready one clk sooner.
    assign addr_vld = sclk_rise && (bit_cnt == 5'd7) && rx_shift[ADDR_BITS-1];
    assign rx_addr  = {rx_shift[ADDR_BITS-2:0], mosi_sync[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else if (ss_fall) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            if (sclk_rise) begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync[1]};
                if (bit_cnt != 5'h1F)
                    bit_cnt <= bit_cnt + 5'd1;
            end
            if (addr_vld)
                tx_shift <= rd_byte;
            else if (sclk_fall && tx_window)
                tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
        end
    end

    assign miso       = ss_low & tx_shift[DATA_BITS-1];
    assign frame_done = ss_rise;
    assign frame      = rx_shift;
    assign frame_full = (bit_cnt == 5'(FRAME_BITS));

endmodule

// File: rtl/gyro_spi_serf.sv
// Inertial sensor SPI responder: configuration registers, Z-gyro sample
// hold with low/high byte lock, and the data-ready interrupt.
module gyro_spi_serf
    import inert_pkg::*;
#(
    parameter int         FRAME_BITS   = FRAME_BITS_DEF,
    parameter logic [7:0] WHO_AM_I_VAL = WHO_AM_I_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               SCLK,
    input  logic               MOSI,
    output logic               MISO,
    output logic               INT,
    input  logic signed [15:0] yaw_in,
    input  logic               new_smpl,
    output logic               gyro_on
);

    logic                  addr_vld;
    logic [ADDR_BITS-1:0]  rx_addr;
    logic [DATA_BITS-1:0]  rd_byte;
    logic                  frame_done;
    logic [FRAME_BITS-1:0] frame;
    logic                  frame_full;

    logic [7:0]  int1_ctrl, ctrl2_g, ctrl5_c;
    logic [15:0] yaw_hold;
    logic        lock, int_q;

    logic                 commit, is_rd, wr_commit, rd_lo, rd_hi, int1_clr;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [DATA_BITS-1:0] cmd_data;

    spi_serf #(.FRAME_BITS(FRAME_BITS)) u_spi (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n       (SS_n),
        .sclk       (SCLK),
        .mosi       (MOSI),
        .miso       (MISO),
        .addr_vld   (addr_vld),
        .rx_addr    (rx_addr),
        .rd_byte    (rd_byte),
        .frame_done (frame_done),
        .frame      (frame),
        .frame_full (frame_full)
    );

    always_comb begin
        // NOTE: default first so a missing case arm cannot infer a latch.
        rd_byte = '0;
        case (rx_addr)
            ADDR_INT1_CTRL: rd_byte = int1_ctrl;
            ADDR_WHO_AM_I:  rd_byte = WHO_AM_I_VAL;
            ADDR_CTRL2_G:   rd_byte = ctrl2_g;
            ADDR_CTRL5_C:   rd_byte = ctrl5_c;
            ADDR_OUTZ_L_G:  rd_byte = yaw_hold[7:0];
            ADDR_OUTZ_H_G:  rd_byte = yaw_hold[15:8];
            default:        rd_byte = '0;
        endcase
    end

    assign is_rd     = frame[RW_BIT];
    assign cmd_addr  = frame[RW_BIT-1 -: ADDR_BITS];
    assign cmd_data  = frame[DATA_BITS-1:0];
    assign commit    = frame_done & frame_full;
    assign wr_commit = commit & ~is_rd;
    assign rd_lo     = commit & is_rd & (cmd_addr == ADDR_OUTZ_L_G);
    assign rd_hi     = commit & is_rd & (cmd_addr == ADDR_OUTZ_H_G);
    assign int1_clr  = wr_commit & (cmd_addr == ADDR_INT1_CTRL) & ~cmd_data[1];

    // NOTE: these are a handful of control registers, not a RAM array, so
    // every one of them takes the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_ctrl <= '0;
            ctrl2_g   <= '0;
            ctrl5_c   <= '0;
        end else if (wr_commit) begin
            case (cmd_addr)
                ADDR_INT1_CTRL: int1_ctrl <= cmd_data;
                ADDR_CTRL2_G:   ctrl2_g   <= cmd_data;
                ADDR_CTRL5_C:   ctrl5_c   <= cmd_data;
                default:        ;
            endcase
        end
    end

    assign gyro_on = int1_ctrl[1] & (ctrl2_g[7:4] != 4'h0);

    // Clears are written last so they win over a same-clk sample; a sample
    // coinciding with the high-byte read is dropped rather than captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yaw_hold <= '0;
            lock     <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            if (new_smpl && !lock && !rd_hi) begin
                yaw_hold <= yaw_in;
                if (gyro_on)
                    int_q <= 1'b1;
            end
            if (rd_lo)
                lock <= 1'b1;
            if (rd_hi) begin
                lock  <= 1'b0;
                int_q <= 1'b0;
            end
            if (int1_clr)
                int_q <= 1'b0;
        end
    end

    assign INT = int_q;

endmodule

// File: tb/tb_gyro_spi_serf.sv
// Directed bench for gyro_spi_serf: an SPI mode-3 initiator drives frames,
// expected read bytes go through a scoreboard queue.
module tb_gyro_spi_serf;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               SS_n = 1'b1;
    logic               SCLK = 1'b1;
    logic               MOSI = 1'b0;
    logic               MISO;
    logic               INT;
    logic signed [15:0] yaw_in = '0;
    logic               new_smpl = 1'b0;
    logic               gyro_on;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    gyro_spi_serf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .INT      (INT),
        .yaw_in   (yaw_in),
        .new_smpl (new_smpl),
        .gyro_on  (gyro_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic half_period();
        repeat (6) @(negedge clk);
    endtask

    // Drives nbits of cmd MSB first with SS_n left low; returns bits 7:0
    // sampled just before the 9th..16th SCLK rises.
    task automatic spi_bits(input logic [15:0] cmd, input int nbits, output logic [7:0] rd);
        rd = '0;
        @(negedge clk);
        SS_n = 1'b0;
        half_period();
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            half_period();
            if (i >= 8)
                rd[15-i] = MISO;
            SCLK = 1'b1;
            half_period();
        end
    endtask

    // Raises SS_n; optionally pulses new_smpl in the very clk of the commit.
    task automatic spi_close(input bit coinc, input logic [15:0] val);
        @(negedge clk);
        SS_n = 1'b1;
        if (coinc) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            yaw_in   = val;
            new_smpl = 1'b1;
            @(negedge clk);
            new_smpl = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [6:0] addr, input logic [7:0] data);
        logic [7:0] unused_rd;
        spi_bits({1'b0, addr, data}, 16, unused_rd);
        spi_close(1'b0, 16'h0000);
    endtask

    task automatic rd_reg(input string tag, input logic [6:0] addr, input logic [7:0] exp,
                          input bit coinc, input logic [15:0] val);
        logic [7:0] rd;
        sb_item_t   item;
        sb_q.push_back('{tag, exp});
        spi_bits({1'b1, addr, 8'h00}, 16, rd);
        spi_close(coinc, val);
        item = sb_q.pop_front();
        check(item.tag, {8'h00, rd}, {8'h00, item.exp});
    endtask

    // Checked half a clk after the capturing edge: one clk after the pulse.
    task automatic sample(input logic [15:0] val);
        @(negedge clk);
        yaw_in   = val;
        new_smpl = 1'b1;
        @(negedge clk);
        new_smpl = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;

        repeat (3) @(negedge clk);
        check("rst_miso", {15'h0, MISO}, 16'h0);
        check("rst_int", {15'h0, INT}, 16'h0);
        check("rst_gyro_on", {15'h0, gyro_on}, 16'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        wr_reg(7'h0D, 8'h02);
        check("gyro_on_int1_only", {15'h0, gyro_on}, 16'h0);
        wr_reg(7'h11, 8'h60);
        check("gyro_on_after_ctrl2", {15'h0, gyro_on}, 16'h1);
        wr_reg(7'h14, 8'h40);

        rd_reg("rd_int1_ctrl", 7'h0D, 8'h02, 1'b0, 16'h0);
        rd_reg("rd_ctrl2_g", 7'h11, 8'h60, 1'b0, 16'h0);
        rd_reg("rd_ctrl5_c", 7'h14, 8'h40, 1'b0, 16'h0);
        rd_reg("rd_who_am_i", 7'h0F, 8'h6A, 1'b0, 16'h0);
        rd_reg("rd_unmapped_2a", 7'h2A, 8'h00, 1'b0, 16'h0);

        // Aborted 10-bit write must leave the register alone.
        spi_bits(16'h11FF, 10, rd);
        spi_close(1'b0, 16'h0);
        rd_reg("abort_wr_ctrl2_g", 7'h11, 8'h60, 1'b0, 16'h0);
        check("abort_wr_int", {15'h0, INT}, 16'h0);

        sample(16'hF123);
        check("int_after_sample", {15'h0, INT}, 16'h1);

        // Aborted high-byte read: no INT clear.
        spi_bits(16'hA700, 10, rd);
        spi_close(1'b0, 16'h0);
        check("abort_rd_int", {15'h0, INT}, 16'h1);

        rd_reg("outz_l_f123", 7'h26, 8'h23, 1'b0, 16'h0);
        sample(16'h0055);
        check("int_locked_sample", {15'h0, INT}, 16'h1);
        rd_reg("outz_h_f123", 7'h27, 8'hF1, 1'b0, 16'h0);
        check("int_after_outz_h", {15'h0, INT}, 16'h0);
        rd_reg("outz_l_no_tear", 7'h26, 8'h23, 1'b0, 16'h0);
        rd_reg("outz_h_no_tear", 7'h27, 8'hF1, 1'b0, 16'h0);

        // High-byte commit coinciding with a new sample.
        sample(16'h1234);
        check("int_sample_1234", {15'h0, INT}, 16'h1);
        rd_reg("outz_l_1234", 7'h26, 8'h34, 1'b0, 16'h0);
        rd_reg("outz_h_coinc", 7'h27, 8'h12, 1'b1, 16'hBEEF);
        check("int_coinc_clear", {15'h0, INT}, 16'h0);
        rd_reg("outz_l_coinc_dropped", 7'h26, 8'h34, 1'b0, 16'h0);
        rd_reg("outz_h_coinc_dropped", 7'h27, 8'h12, 1'b0, 16'h0);
        sample(16'h7777);
        check("int_after_coinc", {15'h0, INT}, 16'h1);

        // Clearing INT1_CTRL[1] forces INT low and disables the gyro.
        wr_reg(7'h0D, 8'h00);
        check("int_forced_low", {15'h0, INT}, 16'h0);
        check("gyro_off", {15'h0, gyro_on}, 16'h0);
        sample(16'h5A3C);
        check("int_gyro_off_sample", {15'h0, INT}, 16'h0);
        rd_reg("outz_l_gyro_off", 7'h26, 8'h3C, 1'b0, 16'h0);
        rd_reg("outz_h_gyro_off", 7'h27, 8'h5A, 1'b0, 16'h0);

        // Asynchronous reset in the middle of a WHO_AM_I read.
        wr_reg(7'h0D, 8'h02);
        sample(16'h0001);
        check("int_before_reset", {15'h0, INT}, 16'h1);
        spi_bits(16'h8F00, 10, rd);
        check("miso_mid_frame", {15'h0, MISO}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_miso", {15'h0, MISO}, 16'h0);
        check("reset_int", {15'h0, INT}, 16'h0);
        check("reset_gyro_on", {15'h0, gyro_on}, 16'h0);
        SS_n = 1'b1;
        SCLK = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd_reg("post_reset_int1", 7'h0D, 8'h00, 1'b0, 16'h0);
        rd_reg("post_reset_outz_l", 7'h26, 8'h00, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
